if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage for the multi-cycle CPU. Holds the program counter, computes the next PC from the control unit's PC source select, and fetches instructions from instruction memory over a variable-latency request/ready handshake. It latches each instruction into the instruction register and holds it for the decode stage until the control unit pulses PCWre. The block sits directly upstream of decode; its IF_InsAddr and IF_nextPC outputs are the CPU's top-level IF observation ports.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that stops fetching.
- TIMEOUT_CYCLES, 16, maximum S_FETCH cycles without imem_ready; used only when IF_TIMEOUT_EN is defined.

- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCWre  in  1  from the control unit; advance the PC and start the next fetch.
- PCSrc  in  2  next-PC select: 00 = PC+4; 01 = branch; 10 = jr; 11 = jump.
- ImExtend  in  32  sign-extended immediate, used by branch.
- JumpAddr  in  26  instruction target field, used by jump.
- RegRs  in  32  rs register value, used by jr.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals IF_InsAddr.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory response strobe.
- IF_InsAddr  out  32  current PC.
- IF_nextPC  out  32  combinational next PC.
- IR  out  32  latched instruction.
- ins_valid  out  1  IR holds a fresh instruction for decode.
- halted  out  1  block is in S_HALT.
- fetch_err  out  1  fetch timeout occurred; constant 0 when IF_TIMEOUT_EN is undefined.

## Operation
- **Reset values:** PC=RESET_PC, IR=0, ins_valid=0, halted=0, fetch_err=0, imem_req=0, state=S_BOOT.
- **Next-PC computation (IF_nextPC), all arithmetic modulo 2^32:**
  - PCSrc 00: PC+4.
  - PCSrc 01: PC+4+(ImExtend<<2); bits shifted out above bit 31 are discarded.
  - PCSrc 10: RegRs, taken unmodified (no alignment fixup).
  - PCSrc 11: {PC+4[31:28], JumpAddr, 2'b00}.
- **States:**
  - S_BOOT: one cycle, imem_req=0, then go to S_FETCH.
  - S_FETCH: imem_req=1.
    - On imem_ready=1: IR<=imem_rdata, ins_valid<=1, go to S_HOLD.
    - PCWre is ignored in this state.
  - S_HOLD: imem_req=0; IR and ins_valid are held until PCWre=1. On PCWre=1:
    - If IR[31:26]==HALT_OP: PC is not updated, ins_valid<=0, halted<=1, go to S_HALT.
    - Otherwise: PC<=IF_nextPC, ins_valid<=0, go to S_FETCH.
  - S_HALT: all outputs frozen (ins_valid=0, imem_req=0). Only Reset exits.
- imem_ready is ignored outside S_FETCH.
- A Reset assertion in any state, including mid-fetch, forces the reset values immediately, without waiting for a clock edge.
- PCSrc, ImExtend, JumpAddr and RegRs are sampled only on the PCWre edge.

## Timing
- Reset deassertion: first imem_req=1 in the 2nd cycle (the cycle after S_BOOT).
- Zero-wait memory (imem_ready in the first S_FETCH cycle): IR and ins_valid are valid in the following cycle.
- Each additional wait cycle adds one cycle of latency.
- A PCWre pulse in S_HOLD produces the new PC on IF_InsAddr and imem_req=1 in the next cycle.
- Minimum instruction period is 2 cycles (S_FETCH, S_HOLD).
- PCWre held high continuously causes one advance per S_HOLD visit, not one per cycle.
- IF_nextPC updates combinationally from PC and the select inputs.

## Configuration
- IF_TIMEOUT_EN defined:
  - A counter runs during S_FETCH and clears on entry to S_FETCH.
  - If TIMEOUT_CYCLES consecutive S_FETCH cycles pass without imem_ready, fetch_err<=1 and halted<=1, go to S_HALT, PC unchanged.
  - fetch_err clears only on Reset.
- IF_TIMEOUT_EN undefined: no counter; S_FETCH waits indefinitely; fetch_err is tied to 0.

## Test plan
- Reset with ready tied high:
  - Expect IF_InsAddr=0 and req=1 in the 2nd cycle.
  - Given imem_rdata=32'h2001_0005, expect IR=32'h2001_0005 and ins_valid=1 in the next cycle.
- Sequential fetch: three PCWre pulses with PCSrc=00 -> IF_InsAddr steps 0, 4, 8, 12.
- Branch and jump from PC=8:
  - ImExtend=32'hFFFF_FFFE with PCSrc=01 -> next PC=4.
  - JumpAddr=26'h10 with PCSrc=11 -> next PC=32'h40.
  - RegRs=32'h100 with PCSrc=10 -> next PC=32'h100.
- Wait states: ready delayed 3 cycles -> IR latched in the cycle after ready; PCWre pulses during S_FETCH cause no PC change.
- Halt: IR=32'hFC00_0000 followed by a PCWre pulse -> halted=1, PC frozen, no further req, even if ready is toggled.
- Reset mid-fetch, then (with IF_TIMEOUT_EN) timeout:
  - Reset asserted during a wait state -> PC=RESET_PC and req=0 immediately.
  - With IF_TIMEOUT_EN and ready held low for 16 cycles -> fetch_err=1, halted=1.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC select, IR latch and the imem request/ready handshake.
// Define IF_TIMEOUT_EN to build in the fetch watchdog that halts with fetch_err after TIMEOUT_CYCLES.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP        = 6'b111111,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImExtend,
    input  logic [25:0] JumpAddr,
    input  logic [31:0] RegRs,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_InsAddr,
    output logic [31:0] IF_nextPC,
    output logic [31:0] IR,
    output logic        ins_valid,
    output logic        halted,
    output logic        fetch_err
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JR     = 2'b10;

    // The watchdog compares against TIMEOUT_CYCLES-1, so a single-cycle budget is meaningless.
    if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
        $error("if_fetch_unit: TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] insReg;
    logic        insValid;
    logic        haltedReg;
    logic [31:0] pcPlus4;
    logic [31:0] branchOffset;
    logic [31:0] nextPc;
    logic        isHaltOp;

`ifdef IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] timeoutCnt;
    logic          fetchErr;
`endif

    // Next-PC mux; shifting the full immediate lets the bits above bit 31 fall off naturally.
    always_comb begin
        pcPlus4      = pc + 32'd4;
        branchOffset = ImExtend << 2;
        nextPc       = pcPlus4;
        case (PCSrc)
            SRC_SEQ:    nextPc = pcPlus4;
            SRC_BRANCH: nextPc = pcPlus4 + branchOffset;
            SRC_JR:     nextPc = RegRs;
            default:    nextPc = {pcPlus4[31:28], JumpAddr, 2'b00};
        endcase
    end

    assign isHaltOp = (insReg[31:26] == HALT_OP);

    // Fetch sequencer: PC only moves on a PCWre seen in S_HOLD, so a held PCWre advances once per instruction.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            insReg    <= '0;
            insValid  <= 1'b0;
            haltedReg <= 1'b0;
`ifdef IF_TIMEOUT_EN
            timeoutCnt <= '0;
            fetchErr   <= 1'b0;
`endif
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
`ifdef IF_TIMEOUT_EN
                    timeoutCnt <= '0;
`endif
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        insReg   <= imem_rdata;
                        insValid <= 1'b1;
                        state    <= S_HOLD;
                    end
`ifdef IF_TIMEOUT_EN
                    else if (timeoutCnt == TIMEOUT_LAST) begin
                        fetchErr  <= 1'b1;
                        haltedReg <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        timeoutCnt <= timeoutCnt + CW'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (PCWre) begin
                        insValid <= 1'b0;
                        if (isHaltOp) begin
                            haltedReg <= 1'b1;
                            state     <= S_HALT;
                        end else begin
                            pc    <= nextPc;
                            state <= S_FETCH;
`ifdef IF_TIMEOUT_EN
                            timeoutCnt <= '0;
`endif
                        end
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign IF_InsAddr = pc;
    assign IF_nextPC  = nextPc;
    assign IR         = insReg;
    assign ins_valid  = insValid;
    assign halted     = haltedReg;

`ifdef IF_TIMEOUT_EN
    assign fetch_err = fetchErr;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus a randomized run against a PC/IR reference model.
// Timeout expectations follow IF_TIMEOUT_EN, matching however the design was built.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] ImExtend;
    logic [25:0] JumpAddr;
    logic [31:0] RegRs;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IF_InsAddr;
    logic [31:0] IF_nextPC;
    logic [31:0] IR;
    logic        ins_valid;
    logic        halted;
    logic        fetch_err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] modelPc;
    logic [31:0] modelIr;

    if_fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
        .ImExtend(ImExtend), .JumpAddr(JumpAddr), .RegRs(RegRs),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .IF_InsAddr(IF_InsAddr), .IF_nextPC(IF_nextPC),
        .IR(IR), .ins_valid(ins_valid), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    // Next-PC rules written as plain arithmetic on 32-bit values.
    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [1:0] src,
                                            input logic [31:0] imm, input logic [25:0] ja,
                                            input logic [31:0] rs);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        case (src)
            2'd0:    return p4;
            2'd1:    return p4 + imm * 32'd4;
            2'd2:    return rs;
            default: return (p4 & 32'hF000_0000) + {6'd0, ja} * 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] randomNonHalt();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic doReset();
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        modelPc = 32'h0;
        modelIr = 32'h0;
    endtask

    task automatic feedWord(input logic [31:0] word);
        imem_rdata = word;
        imem_ready = 1'b1;
        @(negedge CLK);
        imem_ready = 1'b0;
        modelIr = word;
    endtask

    task automatic pulseAdvance(input logic [1:0] src, input logic [31:0] imm,
                                input logic [25:0] ja, input logic [31:0] rs);
        PCSrc = src; ImExtend = imm; JumpAddr = ja; RegRs = rs;
        PCWre = 1'b1;
        @(negedge CLK);
        PCWre = 1'b0;
        modelPc = refNext(modelPc, src, imm, ja, rs);
    endtask

    task automatic test_reset();
        PCWre = 1'b0; PCSrc = 2'b00; ImExtend = '0; JumpAddr = '0; RegRs = '0;
        imem_ready = 1'b1;
        imem_rdata = 32'h2001_0005;
        Reset = 1'b1;
        @(negedge CLK);
        compared++; if (IF_InsAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pc: got %h, expected %h", IF_InsAddr, 32'h0); end
        compared++; if ({imem_req, ins_valid, halted, fetch_err} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b, expected %b", {imem_req, ins_valid, halted, fetch_err}, 4'b0000); end
        compared++; if (IR !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_ir: got %h, expected %h", IR, 32'h0); end
        Reset = 1'b0;
        modelPc = 32'h0;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL boot_req: got %b, expected %b", imem_req, 1'b0); end
        @(negedge CLK);
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL first_req: got %b, expected %b", imem_req, 1'b1); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL first_addr: got %h, expected %h", imem_addr, 32'h0); end
        @(negedge CLK);
        imem_ready = 1'b0;
        modelIr = 32'h2001_0005;
        compared++; if (IR !== 32'h2001_0005) begin mismatched++; $display("[TB] FAIL zero_wait_ir: got %h, expected %h", IR, 32'h2001_0005); end
        compared++; if ({ins_valid, imem_req} !== 2'b10) begin mismatched++; $display("[TB] FAIL zero_wait_valid: got %b, expected %b", {ins_valid, imem_req}, 2'b10); end
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            PCSrc = 2'b00; ImExtend = $urandom; JumpAddr = 26'($urandom); RegRs = $urandom;
            #1;
            compared++; if (IF_nextPC !== refNext(modelPc, 2'b00, ImExtend, JumpAddr, RegRs)) begin mismatched++; $display("[TB] FAIL seq_nextpc: got %h, expected %h", IF_nextPC, refNext(modelPc, 2'b00, ImExtend, JumpAddr, RegRs)); end
            pulseAdvance(2'b00, ImExtend, JumpAddr, RegRs);
            compared++; if (IF_InsAddr !== 32'((i + 1) * 4)) begin mismatched++; $display("[TB] FAIL seq_pc: got %h, expected %h", IF_InsAddr, 32'((i + 1) * 4)); end
            compared++; if ({imem_req, ins_valid} !== 2'b10) begin mismatched++; $display("[TB] FAIL seq_req: got %b, expected %b", {imem_req, ins_valid}, 2'b10); end
            w = randomNonHalt();
            feedWord(w);
            compared++; if (IR !== w) begin mismatched++; $display("[TB] FAIL seq_ir: got %h, expected %h", IR, w); end
        end
    endtask

    task automatic test_branch_jump();
        pulseAdvance(2'b10, 32'h0, 26'h0, 32'h8);
        feedWord(randomNonHalt());
        compared++; if (IF_InsAddr !== 32'h8) begin mismatched++; $display("[TB] FAIL jr_to_8: got %h, expected %h", IF_InsAddr, 32'h8); end
        PCSrc = 2'b01; ImExtend = 32'hFFFF_FFFE;
        #1;
        compared++; if (IF_nextPC !== 32'h4) begin mismatched++; $display("[TB] FAIL branch_back: got %h, expected %h", IF_nextPC, 32'h4); end
        PCSrc = 2'b11; JumpAddr = 26'h10;
        #1;
        compared++; if (IF_nextPC !== 32'h40) begin mismatched++; $display("[TB] FAIL jump_target: got %h, expected %h", IF_nextPC, 32'h40); end
        PCSrc = 2'b10; RegRs = 32'h100;
        #1;
        compared++; if (IF_nextPC !== 32'h100) begin mismatched++; $display("[TB] FAIL jr_target: got %h, expected %h", IF_nextPC, 32'h100); end
        pulseAdvance(2'b11, 32'h0, 26'h10, 32'h0);
        compared++; if (IF_InsAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL jump_taken: got %h, expected %h", IF_InsAddr, 32'h40); end
        feedWord(randomNonHalt());
    endtask

    task automatic test_wait_states();
        logic [31:0] w;
        pulseAdvance(2'b00, 32'h0, 26'h0, 32'h0);
        for (int j = 0; j < 3; j++) begin
            imem_ready = 1'b0;
            PCWre = 1'b1; PCSrc = 2'b11; JumpAddr = 26'($urandom);
            imem_rdata = $urandom;
            @(negedge CLK);
            compared++; if (IF_InsAddr !== modelPc) begin mismatched++; $display("[TB] FAIL wait_pc_hold: got %h, expected %h", IF_InsAddr, modelPc); end
            compared++; if ({imem_req, ins_valid} !== 2'b10) begin mismatched++; $display("[TB] FAIL wait_req: got %b, expected %b", {imem_req, ins_valid}, 2'b10); end
        end
        PCWre = 1'b0;
        w = randomNonHalt();
        feedWord(w);
        compared++; if (IR !== w || ins_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_ir: got %h/%b, expected %h/1", IR, ins_valid, w); end
        compared++; if (IF_InsAddr !== modelPc) begin mismatched++; $display("[TB] FAIL wait_pc_after: got %h, expected %h", IF_InsAddr, modelPc); end
    endtask

    task automatic test_halt();
        logic [31:0] haltWord;
        pulseAdvance(2'b00, 32'h0, 26'h0, 32'h0);
        haltWord = 32'hFC00_0000 | {6'd0, 26'($urandom)};
        feedWord(haltWord);
        compared++; if ({ins_valid, halted} !== 2'b10) begin mismatched++; $display("[TB] FAIL halt_pre: got %b, expected %b", {ins_valid, halted}, 2'b10); end
        PCSrc = 2'b10; RegRs = 32'h0000_0F00;
        PCWre = 1'b1;
        @(negedge CLK);
        PCWre = 1'b0;
        compared++; if ({halted, ins_valid, imem_req} !== 3'b100) begin mismatched++; $display("[TB] FAIL halt_enter: got %b, expected %b", {halted, ins_valid, imem_req}, 3'b100); end
        compared++; if (IF_InsAddr !== modelPc) begin mismatched++; $display("[TB] FAIL halt_pc: got %h, expected %h", IF_InsAddr, modelPc); end
        for (int k = 0; k < 6; k++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            PCWre = 1'($urandom);
            @(negedge CLK);
            compared++; if ({halted, imem_req, ins_valid} !== 3'b100) begin mismatched++; $display("[TB] FAIL halt_frozen: got %b, expected %b", {halted, imem_req, ins_valid}, 3'b100); end
            compared++; if (IF_InsAddr !== modelPc || IR !== haltWord) begin mismatched++; $display("[TB] FAIL halt_state: got %h/%h, expected %h/%h", IF_InsAddr, IR, modelPc, haltWord); end
        end
        PCWre = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        doReset();
        compared++; if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_from_halt: got %b, expected %b", halted, 1'b0); end
        @(negedge CLK);
        feedWord(randomNonHalt());
        pulseAdvance(2'b10, 32'h0, 26'h0, 32'h0000_0200);
        compared++; if (IF_InsAddr !== 32'h200) begin mismatched++; $display("[TB] FAIL mid_pre_pc: got %h, expected %h", IF_InsAddr, 32'h200); end
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        compared++; if (IF_InsAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_reset_pc: got %h, expected %h", IF_InsAddr, 32'h0); end
        compared++; if ({imem_req, ins_valid, halted} !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_reset_req: got %b, expected %b", {imem_req, ins_valid, halted}, 3'b000); end
        @(negedge CLK);
        Reset = 1'b0;
        modelPc = 32'h0;
    endtask

    task automatic test_timeout();
        doReset();
        imem_ready = 1'b0;
        @(negedge CLK);
        for (int k = 2; k <= 16; k++) @(negedge CLK);
        compared++; if ({imem_req, fetch_err, halted} !== 3'b100) begin mismatched++; $display("[TB] FAIL timeout_cycle16: got %b, expected %b", {imem_req, fetch_err, halted}, 3'b100); end
        @(negedge CLK);
`ifdef IF_TIMEOUT_EN
        compared++; if ({imem_req, fetch_err, halted} !== 3'b011) begin mismatched++; $display("[TB] FAIL timeout_hit: got %b, expected %b", {imem_req, fetch_err, halted}, 3'b011); end
        imem_ready = 1'b1;
        @(negedge CLK);
        imem_ready = 1'b0;
        compared++; if ({fetch_err, halted, IF_InsAddr} !== {2'b11, 32'h0}) begin mismatched++; $display("[TB] FAIL timeout_sticky: got %b/%h, expected 11/%h", {fetch_err, halted}, IF_InsAddr, 32'h0); end
`else
        compared++; if ({imem_req, fetch_err, halted} !== 3'b100) begin mismatched++; $display("[TB] FAIL no_timeout: got %b, expected %b", {imem_req, fetch_err, halted}, 3'b100); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [1:0]  src;
        logic [31:0] exp;
        doReset();
        @(negedge CLK);
        for (int n = 0; n < 40; n++) begin
            compared++; if (imem_req !== 1'b1 || imem_addr !== modelPc || IF_InsAddr !== modelPc) begin mismatched++; $display("[TB] FAIL rnd_fetch_addr: got %b/%h, expected 1/%h", imem_req, imem_addr, modelPc); end
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                imem_ready = 1'b0; imem_rdata = $urandom; PCWre = 1'($urandom);
                PCSrc = 2'($urandom); RegRs = $urandom;
                @(negedge CLK);
            end
            PCWre = 1'b0;
            w = randomNonHalt();
            feedWord(w);
            compared++; if (IR !== modelIr || ins_valid !== 1'b1 || imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rnd_ir: got %h/%b/%b, expected %h/1/0", IR, ins_valid, imem_req, modelIr); end
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                imem_ready = 1'($urandom); imem_rdata = $urandom;
                @(negedge CLK);
            end
            imem_ready = 1'b0;
            compared++; if (IR !== modelIr || ins_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rnd_hold: got %h/%b, expected %h/1", IR, ins_valid, modelIr); end
            src = 2'($urandom);
            PCSrc = src; ImExtend = $urandom; JumpAddr = 26'($urandom); RegRs = $urandom;
            exp = refNext(modelPc, src, ImExtend, JumpAddr, RegRs);
            #1;
            compared++; if (IF_nextPC !== exp) begin mismatched++; $display("[TB] FAIL rnd_nextpc src=%0d: got %h, expected %h", src, IF_nextPC, exp); end
            pulseAdvance(src, ImExtend, JumpAddr, RegRs);
        end
    endtask

    task automatic test_back_to_back();
        PCSrc = 2'b00; PCWre = 1'b1; imem_ready = 1'b1;
        imem_rdata = 32'h0400_0001;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (i % 2 == 1) begin
                compared++; if ({imem_req, ins_valid} !== 2'b01 || IF_InsAddr !== modelPc) begin mismatched++; $display("[TB] FAIL b2b_hold: got %b/%h, expected 01/%h", {imem_req, ins_valid}, IF_InsAddr, modelPc); end
            end else begin
                modelPc = modelPc + 32'd4;
                compared++; if ({imem_req, ins_valid} !== 2'b10 || IF_InsAddr !== modelPc) begin mismatched++; $display("[TB] FAIL b2b_fetch: got %b/%h, expected 10/%h", {imem_req, ins_valid}, IF_InsAddr, modelPc); end
            end
        end
        PCWre = 1'b0; imem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_jump();
        test_wait_states();
        test_halt();
        test_reset_mid_fetch();
        test_timeout();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
